// File: rtl/processinho_pkg.sv
// Shared definitions for the processinho calculator datapath.
// Holds the ALU opcodes, the seven-segment codes and the ALU result layout.
package processinho_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_PASA = 4'd11;
  localparam logic [3:0] OP_PASB = 4'd12;
  localparam logic [3:0] OP_INC  = 4'd13;
  localparam logic [3:0] OP_DEC  = 4'd14;
  localparam logic [3:0] OP_MAX  = 4'd15;

  // Active-low segments, [6:0]=gfedcba, [7]=dp (always off)
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;

  // Matches the external result bus: [9]=err, [8]=neg, [7:0]=mag
  typedef struct packed {
    logic       err;
    logic       neg;
    logic [7:0] mag;
  } ula_res_t;

endpackage

// File: rtl/Display.sv
// Latched result to four HEX digits: three decimal digits with
// leading-zero suppression plus a status digit (error / minus / blank).
module Display
  import processinho_pkg::*;
(
  input  ula_res_t   i_result,
  output logic [7:0] o_hex0,
  output logic [7:0] o_hex1,
  output logic [7:0] o_hex2,
  output logic [7:0] o_hex3
);

  logic [11:0] w_bcd;

  // Double-dabble binary-to-BCD on the 8-bit magnitude
  always_comb begin
    w_bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_bcd[3:0]  >= 4'd5) w_bcd[3:0]  = w_bcd[3:0]  + 4'd3;
      if (w_bcd[7:4]  >= 4'd5) w_bcd[7:4]  = w_bcd[7:4]  + 4'd3;
      if (w_bcd[11:8] >= 4'd5) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
      w_bcd = {w_bcd[10:0], i_result.mag[i]};
    end
  end

  bcd_to_seg7 u_units (.i_digit(w_bcd[3:0]),  .i_blank(1'b0),                   .o_seg(o_hex0));
  bcd_to_seg7 u_tens  (.i_digit(w_bcd[7:4]),  .i_blank(i_result.mag < 8'd10),  .o_seg(o_hex1));
  bcd_to_seg7 u_hund  (.i_digit(w_bcd[11:8]), .i_blank(i_result.mag < 8'd100), .o_seg(o_hex2));

  // Status digit: error outranks negative
  always_comb begin
    o_hex3 = SEG_BLANK;
    if (i_result.err)      o_hex3 = SEG_E;
    else if (i_result.neg) o_hex3 = SEG_MINUS;
  end

endmodule

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low seven-segment code, with a blank override.
module bcd_to_seg7
  import processinho_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Non-decimal codes cannot occur from the converter; show blank if they do
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0: o_seg = SEG_DIGIT[0];
        4'd1: o_seg = SEG_DIGIT[1];
        4'd2: o_seg = SEG_DIGIT[2];
        4'd3: o_seg = SEG_DIGIT[3];
        4'd4: o_seg = SEG_DIGIT[4];
        4'd5: o_seg = SEG_DIGIT[5];
        4'd6: o_seg = SEG_DIGIT[6];
        4'd7: o_seg = SEG_DIGIT[7];
        4'd8: o_seg = SEG_DIGIT[8];
        4'd9: o_seg = SEG_DIGIT[9];
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/general_register.sv
// 4-bit operand register with synchronous reset and load enable.
module general_register (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_q;

  // Reset wins over load; otherwise hold
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ula.sv
// ALU (ULA) with the latched result register.
// Divider/modulo logic exists only when PROCESSINHO_DIV_EN is defined;
// otherwise opcodes 3/4 yield zero and the error flag stays 0.
module ula
  import processinho_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_op,
  input  logic       i_latch,
  output ula_res_t   o_result
);

  ula_res_t   w_res;
  ula_res_t   r_result;
  logic [7:0] w_a8;
  logic [7:0] w_b8;

  assign w_a8 = {4'b0, i_a};
  assign w_b8 = {4'b0, i_b};

  // Combinational ALU; flags default clear, only SUB/DEC/DIV/MOD set them
  always_comb begin
    w_res = '0;
    case (i_op)
      OP_ADD: w_res.mag = w_a8 + w_b8;
      OP_SUB: begin
        if (i_a < i_b) begin
          w_res.mag = w_b8 - w_a8;
          w_res.neg = 1'b1;
        end else begin
          w_res.mag = w_a8 - w_b8;
        end
      end
      OP_MUL: w_res.mag = w_a8 * w_b8;
`ifdef PROCESSINHO_DIV_EN
      OP_DIV: begin
        if (i_b == 4'd0) w_res.err = 1'b1;
        else             w_res.mag = {4'b0, i_a / i_b};
      end
      OP_MOD: begin
        if (i_b == 4'd0) w_res.err = 1'b1;
        else             w_res.mag = {4'b0, i_a % i_b};
      end
`else
      OP_DIV: w_res = '0;
      OP_MOD: w_res = '0;
`endif
      OP_AND:  w_res.mag = {4'b0, i_a & i_b};
      OP_OR:   w_res.mag = {4'b0, i_a | i_b};
      OP_XOR:  w_res.mag = {4'b0, i_a ^ i_b};
      OP_NOT:  w_res.mag = {4'b0, ~i_a};
      OP_SHL:  w_res.mag = w_a8 << i_b[1:0];
      OP_SHR:  w_res.mag = w_a8 >> i_b[1:0];
      OP_PASA: w_res.mag = w_a8;
      OP_PASB: w_res.mag = w_b8;
      OP_INC:  w_res.mag = w_a8 + 8'd1;
      OP_DEC: begin
        // 0-1 is shown as magnitude 1 with the negative flag
        if (i_a == 4'd0) begin
          w_res.mag = 8'd1;
          w_res.neg = 1'b1;
        end else begin
          w_res.mag = w_a8 - 8'd1;
        end
      end
      OP_MAX:  w_res.mag = (i_a > i_b) ? w_a8 : w_b8;
      default: w_res = '0;
    endcase
  end

  // Result register: captures the ALU only on latch, so opcode changes alone are invisible
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_result <= '0;
    else if (i_latch) r_result <= w_res;
  end

  assign o_result = r_result;

endmodule

// File: rtl/processinho_datapath.sv
// processinho_datapath: two operand registers, ALU with latched result,
// and decimal seven-segment drive. Optional divider: PROCESSINHO_DIV_EN.
module processinho_datapath
  import processinho_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       setRegA,
  input  logic       setRegB,
  input  logic [3:0] operando,
  input  logic [3:0] ula_operation,
  input  logic       latch_ula,
  output logic [9:0] result,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  ula_res_t   w_result;

  general_register u_reg_a (
    .i_clk(clock), .i_rst(reset), .i_load(setRegA), .i_d(operando), .o_q(w_a)
  );

  general_register u_reg_b (
    .i_clk(clock), .i_rst(reset), .i_load(setRegB), .i_d(operando), .o_q(w_b)
  );

  ula u_ula (
    .i_clk(clock), .i_rst(reset), .i_a(w_a), .i_b(w_b),
    .i_op(ula_operation), .i_latch(latch_ula), .o_result(w_result)
  );

  Display u_disp (
    .i_result(w_result), .o_hex0(HEX0), .o_hex1(HEX1), .o_hex2(HEX2), .o_hex3(HEX3)
  );

  assign result = w_result;

endmodule

// File: tb/tb_processinho_datapath.sv
// Scoreboard bench for processinho_datapath.
module tb_processinho_datapath;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       setRegA = 1'b0, setRegB = 1'b0, latch_ula = 1'b0;
  logic [3:0] operando = '0, ula_operation = '0;
  logic [9:0] result;
  logic [7:0] HEX0, HEX1, HEX2, HEX3;

  processinho_datapath dut (
    .clock(clock), .reset(reset), .setRegA(setRegA), .setRegB(setRegB),
    .operando(operando), .ula_operation(ula_operation), .latch_ula(latch_ula),
    .result(result), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int         mA = 0, mB = 0;
  logic [9:0] mRes = '0;
  logic [9:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(input int a, input int b, input int op);
    int m = 0;
    bit n = 0, e = 0;
    case (op)
      0:  m = a + b;
      1:  if (a < b) begin m = b - a; n = 1; end else m = a - b;
      2:  m = a * b;
`ifdef PROCESSINHO_DIV_EN
      3:  if (b == 0) e = 1; else m = a / b;
      4:  if (b == 0) e = 1; else m = a % b;
`endif
      5:  m = a & b;
      6:  m = a | b;
      7:  m = a ^ b;
      8:  m = 15 - a;
      9:  m = a * (1 << (b % 4));
      10: m = a / (1 << (b % 4));
      11: m = a;
      12: m = b;
      13: m = a + 1;
      14: if (a == 0) begin m = 1; n = 1; end else m = a - 1;
      15: m = (a > b) ? a : b;
      default: m = 0;
    endcase
    return {e, n, 8'(m)};
  endfunction

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'h00;
    endcase
  endfunction

  // Compare all outputs against one expected result word
  task automatic check_outputs(input string tag, input logic [9:0] exp);
    int mag;
    mag = int'(exp[7:0]);
    chk({tag, ".result"}, 32'(result), 32'(exp));
    chk({tag, ".HEX0"}, 32'(HEX0), 32'(seg(mag % 10)));
    chk({tag, ".HEX1"}, 32'(HEX1), (mag < 10)  ? 32'hFF : 32'(seg((mag / 10) % 10)));
    chk({tag, ".HEX2"}, 32'(HEX2), (mag < 100) ? 32'hFF : 32'(seg(mag / 100)));
    chk({tag, ".HEX3"}, 32'(HEX3), exp[9] ? 32'h86 : (exp[8] ? 32'hBF : 32'hFF));
  endtask

  // One clock: drive, update model at the edge (pre-edge A/B for the latch), compare after
  task automatic step(input string tag, input logic rst, input logic sa, input logic sb,
                      input logic [3:0] opnd, input logic [3:0] op, input logic lat);
    logic [9:0] exp;
    reset = rst; setRegA = sa; setRegB = sb; operando = opnd;
    ula_operation = op; latch_ula = lat;
    @(posedge clock);
    if (rst) begin
      mA = 0; mB = 0; mRes = '0;
    end else begin
      if (lat) mRes = model(mA, mB, int'(op));
      if (sa) mA = int'(opnd);
      if (sb) mB = int'(opnd);
    end
    sb_q.push_back(mRes);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_outputs(tag, exp);
    end
    @(negedge clock);
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    step({tag, ".ldA"}, 1'b0, 1'b1, 1'b0, a, op, 1'b0);
    step({tag, ".ldB"}, 1'b0, 1'b0, 1'b1, b, op, 1'b0);
    step({tag, ".lat"}, 1'b0, 1'b0, 1'b0, 4'd0, op, 1'b1);
  endtask

  initial begin
    @(negedge clock);
    // Reset state; loads and latches during reset are ignored
    step("rst0", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step("rstA", 1'b1, 1'b1, 1'b0, 4'd9, 4'd11, 1'b1);
    step("rstB", 1'b1, 1'b0, 1'b1, 4'd3, 4'd12, 1'b1);
    step("pasA0", 1'b0, 1'b0, 1'b0, 4'd0, 4'd11, 1'b1);
    step("pasB0", 1'b0, 1'b0, 1'b0, 4'd0, 4'd12, 1'b1);

    do_op("mul225", 4'd15, 4'd15, 4'd2);
    do_op("subneg", 4'd3, 4'd7, 4'd1);
    do_op("dec0", 4'd0, 4'd7, 4'd14);
`ifdef PROCESSINHO_DIV_EN
    do_op("div0", 4'd9, 4'd0, 4'd3);
    do_op("mod92", 4'd9, 4'd2, 4'd4);
`else
    do_op("divoff", 4'd9, 4'd0, 4'd3);
    do_op("modoff", 4'd9, 4'd2, 4'd4);
`endif

    // Same-cycle load and latch sees the old A
    step("preA2", 1'b0, 1'b1, 1'b0, 4'd2, 4'd11, 1'b0);
    step("ldlat", 1'b0, 1'b1, 1'b0, 4'd5, 4'd11, 1'b1);
    step("lat5", 1'b0, 1'b0, 1'b0, 4'd0, 4'd11, 1'b1);

    // Both strobes together load the same value
    step("ldAB", 1'b0, 1'b1, 1'b1, 4'd6, 4'd0, 1'b0);
    step("add66", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    // Opcode change without latch holds the result
    do_op("add44", 4'd4, 4'd4, 4'd0);
    step("hold", 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
    step("mul16", 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1);

    // Every opcode on boundary and random operands
    for (int op = 0; op < 16; op++) begin
      do_op("op_ff", 4'd15, 4'd15, 4'(op));
      do_op("op_00", 4'd0, 4'd0, 4'(op));
      do_op("op_rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(op));
    end
    for (int k = 0; k < 30; k++)
      do_op("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
